// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: RUN/DRAIN/HALTED control with redirect/stall/halt priority
// and a circular return-address stack that tracks resolved calls and returns.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          RAS_DEPTH    = 8,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] ex_pc,
    input  logic        call,
    input  logic        ret,
    input  logic        halt_dec,
    output logic [15:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted,
    output logic [15:0] ras_top,
    output logic        ras_empty,
    output logic        ras_err
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAS_FULL   = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [DRN_W-1:0]   drain_q, drain_d;

    logic [PTR_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [15:0]        ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   top_idx;
    logic [15:0]        ret_addr;
    logic               ras_op;
    logic               push;
    logic               pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            drain_q <= '0;
            sp_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt_dec) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
            DRAIN: begin
                // A late-resolving branch cancels the halt and resumes fetching.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                    drain_d = '0;
                end else if (stall) begin
                    drain_d = drain_q;
                end else if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign ras_op   = redirect && (state_q != HALTED);
    assign push     = ras_op && call;
    assign pop      = ras_op && ret && !call;
    assign ret_addr = ex_pc + 16'd1;
    assign top_idx  = sp_q - PTR_W'(1);

    // When full, sp already points at the oldest entry, so a push overwrites it.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            sp_d = sp_q + PTR_W'(1);
            if (cnt_q == RAS_FULL) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_q] <= ret_addr;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALTED);
    assign flush       = ras_op;
    assign ras_empty   = (cnt_q == '0);
    assign ras_top     = (cnt_q == '0) ? 16'h0000 : ras_mem[top_idx];
    assign ras_err     = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; next-PC expectations go through a scoreboard queue.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] ex_pc = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        halt_dec = 1'b0;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic [15:0] ras_top;
    logic        ras_empty;
    logic        ras_err;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];

    fetch_sequencer #(
        .RESET_PC(16'h0000),
        .RAS_DEPTH(8),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .ex_pc(ex_pc),
        .call(call),
        .ret(ret),
        .halt_dec(halt_dec),
        .pc(pc),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .halted(halted),
        .ras_top(ras_top),
        .ras_empty(ras_empty),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check this cycle's flush/fetch_valid, then
    // check the PC registered at the following edge.
    task automatic step(input string tag, input logic s, input logic r,
                        input logic [15:0] rpc, input logic [15:0] epc,
                        input logic c, input logic rt, input logic h,
                        input logic exp_flush, input logic exp_fv,
                        input logic [15:0] exp_pc);
        logic [15:0] e;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        ex_pc       = epc;
        call        = c;
        ret         = rt;
        halt_dec    = h;
        exp_q.push_back(exp_pc);
        #1;
        chk({tag, ".flush"}, flush, exp_flush);
        chk({tag, ".fetch_valid"}, fetch_valid, exp_fv);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"}, pc, e);
        stall = 0; redirect = 0; redirect_pc = '0; ex_pc = '0;
        call = 0; ret = 0; halt_dec = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        chk("rst.pc", pc, 16'h0000);
        chk("rst.fetch_valid", fetch_valid, 1'b1);
        chk("rst.flush", flush, 1'b0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.ras_empty", ras_empty, 1'b1);
        chk("rst.ras_top", ras_top, 16'h0000);
        chk("rst.ras_err", ras_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle fetch sequence after reset
        chk("idle0.pc", pc, 16'h0000);
        step("idle1", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0001);
        step("idle2", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0002);
        step("idle3", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0003);

        // Redirect beats stall; plain stall holds
        step("redir10", 0, 1, 16'h0010, 16'h0, 0, 0, 0, 1, 1, 16'h0010);
        step("stall_redir", 1, 1, 16'h0040, 16'h0, 0, 0, 0, 1, 1, 16'h0040);
        step("stall", 1, 0, 16'h0077, 16'h0, 0, 0, 0, 0, 1, 16'h0040);
        step("stall_halt", 1, 0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 16'h0040);

        // call without redirect is ignored
        step("call_nored", 0, 0, 16'h0, 16'h0123, 1, 0, 0, 0, 1, 16'h0041);
        chk("call_nored.ras_empty", ras_empty, 1'b1);

        // Nine calls overflow an 8-entry RAS
        for (int i = 0; i < 9; i++) begin
            step("call", 0, 1, 16'h0300, 16'(16'h0100 + i), 1, 0, 0, 1, 1, 16'h0300);
            chk("call.ras_top", ras_top, 16'(16'h0101 + i));
            chk("call.ras_empty", ras_empty, 1'b0);
            chk("call.ras_err", ras_err, (i == 8) ? 1'b1 : 1'b0);
        end

        // Eight pops drain it; oldest entry 0101 was overwritten
        for (int k = 1; k <= 8; k++) begin
            step("ret", 0, 1, 16'h0310, 16'h0, 0, 1, 0, 1, 1, 16'h0310);
            chk("ret.ras_top", ras_top, (k == 8) ? 16'h0000 : 16'(16'h0109 - k));
            chk("ret.ras_empty", ras_empty, (k == 8) ? 1'b1 : 1'b0);
        end

        // call and ret together push only
        step("callret", 0, 1, 16'h0320, 16'h0400, 1, 1, 0, 1, 1, 16'h0320);
        chk("callret.ras_top", ras_top, 16'h0401);
        chk("callret.ras_empty", ras_empty, 1'b0);

        // Asynchronous reset mid-run clears sticky error and RAS
        rst_n = 1'b0;
        #1;
        chk("rst2.pc", pc, 16'h0000);
        chk("rst2.ras_err", ras_err, 1'b0);
        chk("rst2.ras_empty", ras_empty, 1'b1);
        chk("rst2.ras_top", ras_top, 16'h0000);
        #1;
        rst_n = 1'b1;

        // Pop on empty RAS
        step("pop_empty", 0, 1, 16'h0200, 16'h0, 0, 1, 0, 1, 1, 16'h0200);
        chk("pop_empty.ras_err", ras_err, 1'b1);
        chk("pop_empty.ras_empty", ras_empty, 1'b1);

        // PC wrap
        step("to_ffff", 0, 1, 16'hFFFF, 16'h0, 0, 0, 0, 1, 1, 16'hFFFF);
        step("wrap", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0000);
        step("wrap1", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0001);

        // Halt cancelled by a redirect on the second DRAIN cycle
        step("h43.halt", 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 16'h0001);
        step("h43.drain1", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0001);
        step("h43.drain2", 0, 1, 16'h0050, 16'h0, 0, 0, 0, 1, 0, 16'h0050);
        chk("h43.halted", halted, 1'b0);
        chk("h43.fetch_valid", fetch_valid, 1'b1);
        step("h43.run", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0051);

        // Full halt at 0020
        step("h42.to20", 0, 1, 16'h0020, 16'h0, 0, 0, 0, 1, 1, 16'h0020);
        step("h42.halt", 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 16'h0020);
        step("h42.drain1", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0020);
        chk("h42.d1.halted", halted, 1'b0);
        step("h42.drain2", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0020);
        chk("h42.d2.halted", halted, 1'b0);
        step("h42.drain3", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0020);
        chk("h42.halted", halted, 1'b1);
        step("h42.redir", 0, 1, 16'h0099, 16'h0500, 1, 0, 0, 0, 0, 16'h0020);
        chk("h42.redir.halted", halted, 1'b1);
        chk("h42.redir.ras_empty", ras_empty, 1'b1);
        step("h42.idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0020);

        // Reset from HALTED
        rst_n = 1'b0;
        #1;
        chk("rst3.halted", halted, 1'b0);
        chk("rst3.pc", pc, 16'h0000);
        chk("rst3.fetch_valid", fetch_valid, 1'b1);
        chk("rst3.ras_err", ras_err, 1'b0);
        #1;
        rst_n = 1'b1;
        step("post_rst", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
